// File: rtl/drive_pulse_sequencer.sv
// Drive-channel pulse sequencer: turns gate commands into a stream of
// envelope-memory reads, tracks the modulator pipeline until its last output
// sample, and owns the shared sin/cos LUT write port while no pulse is active.
module drive_pulse_sequencer #(
  parameter int ENVE_ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH          = 10,
  parameter int SIN_LUT_ADDR_WIDTH = 10,
  parameter int SIN_LUT_DATA_WIDTH = 8,
  parameter int MOD_LATENCY        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ENVE_ADDR_WIDTH-1:0]    cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]          cmd_length,
  input  logic                          abort,
  input  logic                          lut_load_valid,
  output logic                          lut_load_ready,
  input  logic                          lut_load_sel,
  input  logic [SIN_LUT_ADDR_WIDTH-1:0] lut_load_addr,
  input  logic [SIN_LUT_DATA_WIDTH-1:0] lut_load_data,
  output logic                          enve_rd_en,
  output logic [ENVE_ADDR_WIDTH-1:0]    enve_rd_addr,
  output logic                          mod_valid_in,
  output logic                          sin_lut_wr_en,
  output logic                          cos_lut_wr_en,
  output logic [SIN_LUT_ADDR_WIDTH-1:0] sinusoidal_lut_wr_addr,
  output logic [SIN_LUT_DATA_WIDTH-1:0] sinusoidal_lut_wr_data,
  output logic                          busy,
  output logic                          pulse_done
);

  // Drain counter must reach MOD_LATENCY; one spare bit keeps the compare simple.
  localparam int DCNT_WIDTH = $clog2(MOD_LATENCY + 1) + 1;
  localparam logic [DCNT_WIDTH-1:0] DCNT_DONE = DCNT_WIDTH'(MOD_LATENCY - 1);
  localparam logic [DCNT_WIDTH-1:0] DCNT_LAST = DCNT_WIDTH'(MOD_LATENCY);
  localparam logic [DCNT_WIDTH-1:0] DCNT_ONE  = DCNT_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  IDX_ONE   = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [LEN_WIDTH-1:0]            idx_q, idx_d;
  logic [LEN_WIDTH-1:0]            len_q, len_d;
  logic [ENVE_ADDR_WIDTH-1:0]      base_q, base_d;
  logic [DCNT_WIDTH-1:0]           dcnt_q, dcnt_d;
  logic                            rd_en_q, rd_en_d;
  logic [ENVE_ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic                            mod_valid_q, mod_valid_d;
  logic                            sin_wr_q, sin_wr_d;
  logic                            cos_wr_q, cos_wr_d;
  logic [SIN_LUT_ADDR_WIDTH-1:0]   lut_addr_q, lut_addr_d;
  logic [SIN_LUT_DATA_WIDTH-1:0]   lut_data_q, lut_data_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic cmd_accept;
  logic lut_accept;

  // Handshakes are combinational; a LUT write wins over a simultaneous command.
  assign lut_load_ready = ~rst & (state_q == IDLE);
  assign cmd_ready      = ~rst & (state_q == IDLE) & ~lut_load_valid;
  assign cmd_accept     = cmd_valid & cmd_ready;
  assign lut_accept     = lut_load_valid & lut_load_ready;

  // Outputs are forced low in any reset cycle, even before the reset edge lands.
  assign enve_rd_en             = rd_en_q & ~rst;
  assign enve_rd_addr           = rd_addr_q & {ENVE_ADDR_WIDTH{~rst}};
  assign mod_valid_in           = mod_valid_q & ~rst;
  assign sin_lut_wr_en          = sin_wr_q & ~rst;
  assign cos_lut_wr_en          = cos_wr_q & ~rst;
  assign sinusoidal_lut_wr_addr = lut_addr_q & {SIN_LUT_ADDR_WIDTH{~rst}};
  assign sinusoidal_lut_wr_data = lut_data_q & {SIN_LUT_DATA_WIDTH{~rst}};
  assign busy                   = busy_q & ~rst;
  assign pulse_done             = done_q & ~rst;

  // Next-state and next-output logic for the IDLE/PLAY/DRAIN sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    dcnt_d      = dcnt_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    mod_valid_d = rd_en_q;
    sin_wr_d    = 1'b0;
    cos_wr_d    = 1'b0;
    lut_addr_d  = lut_addr_q;
    lut_data_d  = lut_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (lut_accept) begin
          sin_wr_d   = ~lut_load_sel;
          cos_wr_d   = lut_load_sel;
          lut_addr_d = lut_load_addr;
          lut_data_d = lut_load_data;
        end else if (cmd_accept) begin
          if (cmd_length == {LEN_WIDTH{1'b0}}) begin
            // Empty gate: report completion without touching the datapath.
            done_d = 1'b1;
          end else begin
            state_d   = PLAY;
            busy_d    = 1'b1;
            len_d     = cmd_length;
            base_d    = cmd_base_addr;
            idx_d     = IDX_ONE;
            rd_en_d   = 1'b1;
            rd_addr_d = cmd_base_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        // idx_q is the index of the next read; the read in an abort cycle already issued.
        if ((idx_q == len_q) || abort) begin
          state_d = DRAIN;
          dcnt_d  = {DCNT_WIDTH{1'b0}};
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + ENVE_ADDR_WIDTH'(idx_q);
          idx_d     = idx_q + IDX_ONE;
        end
      end
      DRAIN: begin
        // Wait out the modulator pipeline; done is registered so it lands on the last DRAIN cycle.
        done_d = (dcnt_q == DCNT_DONE);
        if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = {LEN_WIDTH{1'b0}};
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {LEN_WIDTH{1'b0}};
      len_q       <= {LEN_WIDTH{1'b0}};
      base_q      <= {ENVE_ADDR_WIDTH{1'b0}};
      dcnt_q      <= {DCNT_WIDTH{1'b0}};
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {ENVE_ADDR_WIDTH{1'b0}};
      mod_valid_q <= 1'b0;
      sin_wr_q    <= 1'b0;
      cos_wr_q    <= 1'b0;
      lut_addr_q  <= {SIN_LUT_ADDR_WIDTH{1'b0}};
      lut_data_q  <= {SIN_LUT_DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      dcnt_q      <= dcnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      mod_valid_q <= mod_valid_d;
      sin_wr_q    <= sin_wr_d;
      cos_wr_q    <= cos_wr_d;
      lut_addr_q  <= lut_addr_d;
      lut_data_q  <= lut_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_drive_pulse_sequencer.sv
// Self-checking bench for drive_pulse_sequencer: a table of gate commands with
// cycle-exact expectations, scoreboard queues for envelope reads and LUT writes,
// and hand-written sequences for LUT arbitration and reset during a pulse.
module tb_drive_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_base_addr;
  logic [9:0]  cmd_length;
  logic        abort;
  logic        lut_load_valid;
  logic        lut_load_ready;
  logic        lut_load_sel;
  logic [9:0]  lut_load_addr;
  logic [7:0]  lut_load_data;
  logic        enve_rd_en;
  logic [9:0]  enve_rd_addr;
  logic        mod_valid_in;
  logic        sin_lut_wr_en;
  logic        cos_lut_wr_en;
  logic [9:0]  sinusoidal_lut_wr_addr;
  logic [7:0]  sinusoidal_lut_wr_data;
  logic        busy;
  logic        pulse_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [9:0] base;
    logic [9:0] len;
    int         abort_k;     // cycle after accept in which abort is high (0 = never)
    bit         lut_during;  // hold a LUT write request for the whole pulse
    int         exp_reads;   // expected number of envelope reads
  } vec_t;

  typedef struct {
    bit         sel;
    logic [9:0] addr;
    logic [7:0] data;
    int         at_cyc;
  } lut_exp_t;

  logic [9:0] exp_addr_q[$];
  lut_exp_t   exp_lut_q[$];
  vec_t       vecs[9];

  drive_pulse_sequencer dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_base_addr          (cmd_base_addr),
    .cmd_length             (cmd_length),
    .abort                  (abort),
    .lut_load_valid         (lut_load_valid),
    .lut_load_ready         (lut_load_ready),
    .lut_load_sel           (lut_load_sel),
    .lut_load_addr          (lut_load_addr),
    .lut_load_data          (lut_load_data),
    .enve_rd_en             (enve_rd_en),
    .enve_rd_addr           (enve_rd_addr),
    .mod_valid_in           (mod_valid_in),
    .sin_lut_wr_en          (sin_lut_wr_en),
    .cos_lut_wr_en          (cos_lut_wr_en),
    .sinusoidal_lut_wr_addr (sinusoidal_lut_wr_addr),
    .sinusoidal_lut_wr_data (sinusoidal_lut_wr_data),
    .busy                   (busy),
    .pulse_done             (pulse_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"},  32'(cmd_ready), 32'd0);
    check({tag, "_lut_ready"},  32'(lut_load_ready), 32'd0);
    check({tag, "_rd_en"},      32'(enve_rd_en), 32'd0);
    check({tag, "_rd_addr"},    32'(enve_rd_addr), 32'd0);
    check({tag, "_mod_valid"},  32'(mod_valid_in), 32'd0);
    check({tag, "_lut_wr"},     32'({sin_lut_wr_en, cos_lut_wr_en}), 32'd0);
    check({tag, "_lut_wrdata"}, 32'({sinusoidal_lut_wr_addr, sinusoidal_lut_wr_data}), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(pulse_done), 32'd0);
  endtask

  // Envelope-read scoreboard: every read must match the next expected address.
  always @(negedge clk) begin
    if (enve_rd_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: read of addr %0d with no read expected (cycle %0d)", enve_rd_addr, cyc);
      end else begin
        check("rd_addr", 32'(enve_rd_addr), 32'(exp_addr_q.pop_front()));
      end
    end
  end

  // LUT-write scoreboard: each write must match sel/addr/data and the expected cycle.
  always @(negedge clk) begin
    if ((sin_lut_wr_en === 1'b1) || (cos_lut_wr_en === 1'b1)) begin
      if (exp_lut_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lut_unexpected: LUT write sin=%0b cos=%0b with none expected (cycle %0d)",
                 sin_lut_wr_en, cos_lut_wr_en, cyc);
      end else begin
        lut_exp_t e;
        e = exp_lut_q.pop_front();
        check("lut_cycle", 32'(cyc), 32'(e.at_cyc));
        check("lut_cos_en", 32'(cos_lut_wr_en), 32'(e.sel));
        check("lut_sin_en", 32'(sin_lut_wr_en), 32'(!e.sel));
        check("lut_addr", 32'(sinusoidal_lut_wr_addr), 32'(e.addr));
        check("lut_data", 32'(sinusoidal_lut_wr_data), 32'(e.data));
      end
    end
  end

  // Issues one gate command (caller is just after a posedge) and checks every
  // cycle until the sequencer is back in IDLE. Returns just after a posedge.
  task automatic run_pulse(input vec_t v);
    int  nexp;
    bit  pushed;
    bit  exp_idle;
    logic [9:0] a;
    nexp   = v.exp_reads;
    pushed = 1'b0;
    cmd_valid     = 1'b1;
    cmd_base_addr = v.base;
    cmd_length    = v.len;
    @(negedge clk);
    check("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < nexp; i++) begin
      a = v.base + 10'(i);
      exp_addr_q.push_back(a);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (v.lut_during) begin
      lut_load_valid = 1'b1;
      lut_load_sel   = 1'b0;
      lut_load_addr  = 10'h155;
      lut_load_data  = 8'hA5;
    end
    for (int c = 1; c <= nexp + 5; c++) begin
      abort = (c == v.abort_k);
      @(negedge clk);
      exp_idle = (v.len == 10'd0) || (c > nexp + 4);
      check("rd_en", 32'(enve_rd_en), 32'(c <= nexp));
      check("mod_valid_in", 32'(mod_valid_in), 32'((c >= 2) && (c <= nexp + 1)));
      check("pulse_done", 32'(pulse_done), 32'((v.len == 10'd0) ? (c == 1) : (c == nexp + 4)));
      check("busy", 32'(busy), 32'((v.len != 10'd0) && (c <= nexp + 4)));
      check("cmd_ready", 32'(cmd_ready), 32'(exp_idle && !lut_load_valid));
      check("lut_load_ready", 32'(lut_load_ready), 32'(exp_idle));
      if (exp_idle && lut_load_valid && !pushed) begin
        exp_lut_q.push_back('{sel: lut_load_sel, addr: lut_load_addr, data: lut_load_data, at_cyc: cyc + 1});
        pushed = 1'b1;
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (pushed) begin
        lut_load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_base_addr  = 10'd0;
    cmd_length     = 10'd0;
    abort          = 1'b0;
    lut_load_valid = 1'b0;
    lut_load_sel   = 1'b0;
    lut_load_addr  = 10'd0;
    lut_load_data  = 8'd0;

    vecs[0] = '{base: 10'd5,    len: 10'd4,  abort_k: 0, lut_during: 1'b0, exp_reads: 4};
    vecs[1] = '{base: 10'd1022, len: 10'd4,  abort_k: 0, lut_during: 1'b0, exp_reads: 4};
    vecs[2] = '{base: 10'd7,    len: 10'd0,  abort_k: 0, lut_during: 1'b0, exp_reads: 0};
    vecs[3] = '{base: 10'd100,  len: 10'd10, abort_k: 3, lut_during: 1'b0, exp_reads: 3};
    vecs[4] = '{base: 10'd300,  len: 10'd3,  abort_k: 5, lut_during: 1'b0, exp_reads: 3};
    vecs[5] = '{base: 10'd1023, len: 10'd1,  abort_k: 0, lut_during: 1'b0, exp_reads: 1};
    vecs[6] = '{base: 10'd40,   len: 10'd6,  abort_k: 0, lut_during: 1'b1, exp_reads: 6};
    vecs[7] = '{base: 10'd500,  len: 10'd5,  abort_k: 1, lut_during: 1'b0, exp_reads: 1};
    vecs[8] = '{base: 10'd10,   len: 10'd2,  abort_k: 2, lut_during: 1'b0, exp_reads: 2};

    // Reset: outputs held at zero throughout.
    @(negedge clk);
    check_all_zero("reset_a");
    @(negedge clk);
    check_all_zero("reset_b");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_reset_lut_ready", 32'(lut_load_ready), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Table of gate commands.
    for (int i = 0; i < 9; i++) begin
      run_pulse(vecs[i]);
    end

    // LUT write and command in the same IDLE cycle: LUT wins, command goes next cycle.
    lut_load_valid = 1'b1;
    lut_load_sel   = 1'b1;
    lut_load_addr  = 10'd3;
    lut_load_data  = 8'h7F;
    cmd_valid      = 1'b1;
    cmd_base_addr  = 10'd50;
    cmd_length     = 10'd2;
    @(negedge clk);
    check("arb_lut_ready", 32'(lut_load_ready), 32'd1);
    check("arb_cmd_ready", 32'(cmd_ready), 32'd0);
    exp_lut_q.push_back('{sel: 1'b1, addr: 10'd3, data: 8'h7F, at_cyc: cyc + 1});
    @(posedge clk);
    #1;
    lut_load_valid = 1'b0;
    run_pulse('{base: 10'd50, len: 10'd2, abort_k: 0, lut_during: 1'b0, exp_reads: 2});

    // Reset in the middle of PLAY: no further reads, no pulse_done.
    cmd_valid     = 1'b1;
    cmd_base_addr = 10'd200;
    cmd_length    = 10'd10;
    @(negedge clk);
    check("rstplay_accept", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      exp_addr_q.push_back(10'd200 + 10'(i));
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_in_play");
    check("rst_in_play_reads_before", 32'(exp_addr_q.size()), 32'd8);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr_q.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("after_rst_done", 32'(pulse_done), 32'd0);
      check("after_rst_mod_valid", 32'(mod_valid_in), 32'd0);
      check("after_rst_busy", 32'(busy), 32'd0);
      check("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    @(posedge clk);
    #1;

    check("rd_scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);
    check("lut_scoreboard_empty", 32'(exp_lut_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
